// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_if
// Description : Bundle of the register-file access signals: two write ports,
//               two combinational read ports, sequential-clear request and
//               the busy / conflict status flags.
// Modports    : master - drives requests, samples read data and status
//               slave  - the register file itself
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              clear_req;
  logic              busy;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] waddr0;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [ADDR_W-1:0] raddr0;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              conflict;

  modport master (
    output clear_req, we0, we1, waddr0, waddr1, wdata0, wdata1, raddr0, raddr1,
    input  busy, rdata0, rdata1, conflict
  );

  modport slave (
    input  clear_req, we0, we1, waddr0, waddr1, wdata0, wdata1, raddr0, raddr1,
    output busy, rdata0, rdata1, conflict
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : 2**ADDR_W x DATA_W register file, two write ports (port 1 wins
//               on a same-address write), two combinational read ports, and a
//               sequential clear that zeroes one entry per cycle.
// Ports       : clk    - clock, rising edge
//               reset  - synchronous active-high reset
//               rf_if  - regfile_mp_if.slave access bundle
// Config      : RF_BYPASS_EN - when defined, reads forward same-cycle
//               committing write data (port 1 priority).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  wire           clk,
  input  wire           reset,
  regfile_mp_if.slave   rf_if
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              conflict_q, conflict_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              is_idle;
  logic              wz0, wz1;
  logic              wr0_commit, wr1_commit;
  logic [DATA_W-1:0] arr_rd0, arr_rd1;

  assign is_idle = (state_q == S_IDLE);

  // Writes aimed at the hardwired zero entry are treated as no write at all,
  // so they neither store nor raise conflict.
  assign wz0 = (ZERO_REG != 0) && (rf_if.waddr0 == '0);
  assign wz1 = (ZERO_REG != 0) && (rf_if.waddr1 == '0);

  assign wr0_commit = rf_if.we0 && is_idle && !reset && !wz0;
  assign wr1_commit = rf_if.we1 && is_idle && !reset && !wz1;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    conflict_d = wr0_commit && wr1_commit && (rf_if.waddr0 == rf_if.waddr1);
    case (state_q)
      S_IDLE: begin
        if (rf_if.clear_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- storage
  // Port 1 is assigned last so it wins when both ports hit the same entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == S_CLEAR) begin
      mem_q[idx_q] <= '0;
    end else begin
      if (wr0_commit) mem_q[rf_if.waddr0] <= rf_if.wdata0;
      if (wr1_commit) mem_q[rf_if.waddr1] <= rf_if.wdata1;
    end
  end

  // ---------------------------------------------------------------- reads
  if (ZERO_REG != 0) begin : g_zero_reg
    assign arr_rd0 = (rf_if.raddr0 == '0) ? '0 : mem_q[rf_if.raddr0];
    assign arr_rd1 = (rf_if.raddr1 == '0) ? '0 : mem_q[rf_if.raddr1];
  end else begin : g_plain_reg
    assign arr_rd0 = mem_q[rf_if.raddr0];
    assign arr_rd1 = mem_q[rf_if.raddr1];
  end

`ifdef RF_BYPASS_EN
  // The commit qualifiers already exclude CLEAR, reset and the zero entry.
  always_comb begin
    rf_if.rdata0 = arr_rd0;
    if (wr1_commit && (rf_if.waddr1 == rf_if.raddr0)) begin
      rf_if.rdata0 = rf_if.wdata1;
    end else if (wr0_commit && (rf_if.waddr0 == rf_if.raddr0)) begin
      rf_if.rdata0 = rf_if.wdata0;
    end
  end

  always_comb begin
    rf_if.rdata1 = arr_rd1;
    if (wr1_commit && (rf_if.waddr1 == rf_if.raddr1)) begin
      rf_if.rdata1 = rf_if.wdata1;
    end else if (wr0_commit && (rf_if.waddr0 == rf_if.raddr1)) begin
      rf_if.rdata1 = rf_if.wdata0;
    end
  end
`else
  assign rf_if.rdata0 = arr_rd0;
  assign rf_if.rdata1 = arr_rd1;
`endif

  assign rf_if.busy     = (state_q == S_CLEAR);
  assign rf_if.conflict = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp. Expected values
//               are queued when stimulus is applied and popped when the DUT
//               output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .rf_if (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  task automatic push(input string tag, input logic [31:0] e);
    sb_t item;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_t item;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_underflow observed=%h expected=queued_entry", obs);
    end else begin
      item = sb.pop_front();
      assert (obs === item.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", item.tag, obs, item.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clear_req = 1'b0;
    bus.we0 = 1'b0;  bus.we1 = 1'b0;
    bus.waddr0 = '0; bus.waddr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic chk_rd0(input string tag, input logic [4:0] a, input logic [31:0] e);
    bus.raddr0 = a;
    #1;
    push(tag, e);
    pop_check(bus.rdata0);
  endtask

  task automatic chk_rd1(input string tag, input logic [4:0] a, input logic [31:0] e);
    bus.raddr1 = a;
    #1;
    push(tag, e);
    pop_check(bus.rdata1);
  endtask

  task automatic fill_all(input logic [31:0] base);
    for (int i = 0; i < DEPTH / 2; i++) begin
      bus.we0 = 1'b1; bus.waddr0 = 5'(2 * i);     bus.wdata0 = base + 32'(2 * i);
      bus.we1 = 1'b1; bus.waddr1 = 5'(2 * i + 1); bus.wdata1 = base + 32'(2 * i + 1);
      step();
    end
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      chk_rd0(tag, 5'(i), 32'h0);
    end
  endtask

  initial begin
    int busy_cnt;

    // ---- reset state
    reset = 1'b1;
    idle_inputs();
    bus.raddr0 = '0;
    bus.raddr1 = '0;
    step();
    step();
    push("rst_busy", 32'h0);     pop_check(32'(bus.busy));
    push("rst_conflict", 32'h0); pop_check(32'(bus.conflict));
    reset = 1'b0;
    chk_rd0("rst_entry3", 5'd3, 32'h0);

    // ---- single write, read back next cycle
    bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'hDEADBEEF;
    step();
    idle_inputs();
    chk_rd0("wr_rd3", 5'd3, 32'hDEADBEEF);

    // ---- same-address dual write: port 1 wins, conflict one cycle
    bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h11;
    bus.we1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h22;
    step();
    idle_inputs();
    push("conflict_set", 32'h1); pop_check(32'(bus.conflict));
    chk_rd1("dual_rd7", 5'd7, 32'h22);
    step();
    push("conflict_clr", 32'h0); pop_check(32'(bus.conflict));

    // ---- different-address dual write: no conflict
    bus.we0 = 1'b1; bus.waddr0 = 5'd12; bus.wdata0 = 32'hC0C0;
    bus.we1 = 1'b1; bus.waddr1 = 5'd13; bus.wdata1 = 32'hD0D0;
    step();
    idle_inputs();
    push("conflict_diff", 32'h0); pop_check(32'(bus.conflict));
    chk_rd0("diff_rd12", 5'd12, 32'hC0C0);
    chk_rd1("diff_rd13", 5'd13, 32'hD0D0);

    // ---- zero register
    bus.we0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFFFFFFFF;
    bus.we1 = 1'b1; bus.waddr1 = 5'd0; bus.wdata1 = 32'h5;
    step();
    idle_inputs();
    push("conflict_zero", 32'h0); pop_check(32'(bus.conflict));
    chk_rd0("zero_rd0", 5'd0, 32'h0);

    // ---- same-cycle read of a committing write
    bus.we1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h33;
    step();
    bus.we1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h55;
`ifdef RF_BYPASS_EN
    chk_rd1("bypass_rd9", 5'd9, 32'h55);
`else
    chk_rd1("nobypass_rd9", 5'd9, 32'h33);
`endif
    step();
    idle_inputs();
    chk_rd1("after_rd9", 5'd9, 32'h55);

    // ---- full clear sequence
    fill_all(32'hA0000000);
    chk_rd0("fill_rd17", 5'd17, 32'hA0000011);
    bus.clear_req = 1'b1;
    bus.we0 = 1'b1; bus.waddr0 = 5'd4; bus.wdata0 = 32'h77;
    step();
    idle_inputs();
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      push("clr_busy", (k < 32) ? 32'h1 : 32'h0);
      pop_check(32'(bus.busy));
      if (bus.busy) busy_cnt++;
      if (k == 0) chk_rd1("clr_same_cycle_wr4", 5'd4, 32'h77);
      if (k == 8) begin
        chk_rd0("clr_partial_rd2", 5'd2, 32'h0);
        chk_rd1("clr_partial_rd20", 5'd20, 32'hA0000014);
      end
      if (k == 10) begin
        bus.we0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hBAD;
        bus.clear_req = 1'b1;
      end
      if (k == 11) idle_inputs();
      step();
    end
    push("clr_busy_cycles", 32'd32); pop_check(32'(busy_cnt));
    check_all_zero("clr_all_zero");

    // ---- reset in the middle of a clear
    fill_all(32'hB0000000);
    bus.clear_req = 1'b1;
    step();
    idle_inputs();
    for (int k = 0; k < 9; k++) step();
    push("mid_busy10", 32'h1); pop_check(32'(bus.busy));
    reset = 1'b1;
    step();
    reset = 1'b0;
    push("mid_rst_busy", 32'h0);     pop_check(32'(bus.busy));
    push("mid_rst_conflict", 32'h0); pop_check(32'(bus.conflict));
    check_all_zero("mid_rst_zero");
    bus.we0 = 1'b1; bus.waddr0 = 5'd2; bus.wdata0 = 32'h1234;
    step();
    idle_inputs();
    chk_rd0("post_rst_rd2", 5'd2, 32'h1234);

    push("sb_empty", 32'h0); pop_check(32'(sb.size() - 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the directed sequence finishes in a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, entry width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, entry 0 hardwired to zero when 1.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clear_req  input  1  request for a sequential clear of all entries.
REQ-007 busy  output  1  high while the sequential clear runs.
REQ-008 we0 / we1  input  1  write enables, ports 0 and 1.
REQ-009 waddr0 / waddr1  input  ADDR_W  write addresses.
REQ-010 wdata0 / wdata1  input  DATA_W  write data.
REQ-011 raddr0 / raddr1  input  ADDR_W  read addresses.
REQ-012 rdata0 / rdata1  output  DATA_W  combinational read data.
REQ-013 conflict  output  1  registered flag: previous cycle had both ports writing the same address.

Function
REQ-014 Reads SHALL be combinational, zero-latency, from the current array contents.
REQ-015 With ZERO_REG=1, reads of address 0 SHALL return 0 and writes to address 0 SHALL be discarded; with ZERO_REG=0, entry 0 is ordinary.
REQ-016 Writes SHALL commit on the rising edge when the write enable is high, state is IDLE and reset is low.
REQ-017 Both ports writing the same address in one cycle: port 1 data SHALL be stored; conflict SHALL be 1 on the following cycle only.
REQ-018 conflict SHALL be 0 for any cycle not preceded by a same-address dual write (address 0 with ZERO_REG=1 counts as no conflict).
REQ-019 FSM states: IDLE, CLEAR; IDLE->CLEAR on clear_req=1; CLEAR->IDLE after the entry at index depth-1 is cleared.
REQ-020 Entry to CLEAR SHALL load an index counter with 0; each CLEAR cycle zeroes the entry at the counter and increments it, taking exactly 2**ADDR_W cycles.
REQ-021 busy SHALL be 1 in every CLEAR cycle and 0 in IDLE.
REQ-022 Writes presented in the same cycle as an accepted clear_req SHALL commit, then be overwritten by the clear.
REQ-023 Writes during CLEAR SHALL be discarded; clear_req during CLEAR SHALL be ignored.
REQ-024 Reads during CLEAR SHALL return 0 for already-cleared entries and old contents for the rest.

Reset
REQ-025 reset=1 at a rising edge SHALL zero all entries, force IDLE, clear the index counter, and drive busy=0 and conflict=0.
REQ-026 reset SHALL override a clear in progress and any concurrent write or clear_req.

Configuration
REQ-027 Macro RF_BYPASS_EN defined: a read whose address matches an enabled, committing write in the same cycle SHALL return the write data (port 1 priority; never for address 0 with ZERO_REG=1; never in CLEAR).
REQ-028 Macro RF_BYPASS_EN undefined: reads SHALL return the pre-edge array value, with no forwarding logic.

Verification
REQ-029 Reset, then we0=1 waddr0=3 wdata0=0xDEADBEEF; next cycle raddr0=3 -> rdata0=0xDEADBEEF.
REQ-030 we0=1/we1=1 both to address 7, data 0x11 and 0x22 -> entry 7 reads 0x22; conflict=1 for exactly one cycle.
REQ-031 Write 0xFFFFFFFF to address 0 (ZERO_REG=1) -> rdata0=0 at raddr0=0; conflict=0 on a dual write to address 0.
REQ-032 Fill all 32 entries, pulse clear_req -> busy high exactly 32 cycles; a write to address 5 during CLEAR is discarded; afterwards every entry reads 0.
REQ-033 Assert reset at the 10th CLEAR cycle -> next cycle busy=0, all entries 0, a write to address 2 then succeeds.
REQ-034 Same-cycle we1=1 waddr1=9 wdata1=0x55 with raddr1=9 -> rdata1=0x55 with RF_BYPASS_EN, old value without.
